// File: rtl/rx_burst.sv
// Receive burst controller: qualifies burst energy on incoming I/Q samples and
// captures a fixed-length burst into a FIFO that feeds the demodulator.
module rx_burst #(
    parameter int SAMPLE_BITS   = 8,
    parameter int BURST_SAMPLES = 625,
    parameter int QUALIFY_COUNT = 4,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   arm_burst,
    output logic                   is_armed,
    input  logic [SAMPLE_BITS:0]   energy_threshold,
    input  logic [SAMPLE_BITS-1:0] rfchain_inphase,
    input  logic [SAMPLE_BITS-1:0] rfchain_quadrature,
    input  logic                   rfchain_valid,
    output logic [SAMPLE_BITS-1:0] demod_inphase,
    output logic [SAMPLE_BITS-1:0] demod_quadrature,
    output logic                   demod_valid,
    input  logic                   demod_ready,
    output logic                   demod_last,
    output logic                   burst_active,
    output logic                   overflow
);

    // state    | meaning
    // IDLE     | waiting for arm_burst
    // ARMED    | watching for the first above-threshold sample
    // QUALIFY  | counting a run of consecutive above-threshold samples
    // CAPTURE  | pushing delayed samples into the FIFO
    // DRAIN    | capture done, waiting for the last sample to leave
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_QUALIFY,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    localparam int MW = SAMPLE_BITS + 1;
    localparam int SW = 2 * SAMPLE_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(QUALIFY_COUNT + 1);
    localparam int CW = $clog2(BURST_SAMPLES + 1);

    logic [MW-1:0] ext_i, ext_q, abs_i, abs_q, mag_d, mag_q;
    logic          smp_vld_q;
    logic [SW-1:0] dl_q [QUALIFY_COUNT];
    logic [SW-1:0] tap;
    logic          above;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          push, push_last, start_cap, ovf_clr;

    logic [SW-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q, mem_cnt, occ_q;
    logic [AW-1:0]   wr_idx, wr_idx_prev, rd_idx;
    logic            full, pop, wr_en, drop, load;

    logic [SW-1:0]   out_data_q;
    logic            out_vld_q, out_last_q, ovf_q;

    // Magnitude at one extra bit so |-2^(N-1)| is representable.
    assign ext_i = {rfchain_inphase[SAMPLE_BITS-1], rfchain_inphase};
    assign ext_q = {rfchain_quadrature[SAMPLE_BITS-1], rfchain_quadrature};
    assign abs_i = ext_i[MW-1] ? MW'(~ext_i + MW'(1)) : ext_i;
    assign abs_q = ext_q[MW-1] ? MW'(~ext_q + MW'(1)) : ext_q;
    assign mag_d = abs_i + abs_q;

    // dl_q[0] always holds the sample whose magnitude sits in mag_q, so the
    // tap is the start of a qualifying run when that run completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_q     <= '0;
            smp_vld_q <= 1'b0;
            for (int k = 0; k < QUALIFY_COUNT; k++) dl_q[k] <= '0;
        end else begin
            smp_vld_q <= rfchain_valid;
            if (rfchain_valid) begin
                mag_q   <= mag_d;
                dl_q[0] <= {rfchain_inphase, rfchain_quadrature};
                for (int k = 1; k < QUALIFY_COUNT; k++) dl_q[k] <= dl_q[k-1];
            end
        end
    end

    assign tap   = dl_q[QUALIFY_COUNT-1];
    assign above = (mag_q >= energy_threshold);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        rem_d     = rem_q;
        push      = 1'b0;
        push_last = 1'b0;
        start_cap = 1'b0;
        ovf_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_burst) begin
                    state_d = ST_ARMED;
                    run_d   = '0;
                    ovf_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (smp_vld_q && above) begin
                    if (QUALIFY_COUNT == 1) begin
                        start_cap = 1'b1;
                    end else begin
                        state_d = ST_QUALIFY;
                        run_d   = RW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (smp_vld_q) begin
                    if (!above) begin
                        state_d = ST_ARMED;
                        run_d   = '0;
                    end else if (run_q == RW'(QUALIFY_COUNT - 1)) begin
                        start_cap = 1'b1;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (smp_vld_q) begin
                    push  = 1'b1;
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        push_last = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_cap) begin
            push      = 1'b1;
            run_d     = '0;
            rem_d     = CW'(BURST_SAMPLES - 1);
            push_last = (BURST_SAMPLES == 1);
            state_d   = (BURST_SAMPLES == 1) ? ST_DRAIN : ST_CAPTURE;
        end
    end

    // Occupancy counts the output register as one of the FIFO entries.
    assign wr_idx      = wr_ptr_q[AW-1:0];
    assign rd_idx      = rd_ptr_q[AW-1:0];
    assign wr_idx_prev = wr_idx - AW'(1);
    assign mem_cnt     = wr_ptr_q - rd_ptr_q;
    assign full        = (occ_q == (AW+1)'(FIFO_DEPTH));
    assign pop         = out_vld_q & demod_ready;
    assign wr_en       = push & (~full | pop);
    assign drop        = push & full & ~pop;
    assign load        = (~out_vld_q | pop) & (mem_cnt != '0);

    // A dropped final sample moves the last marker onto the newest stored one.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx]      <= tap;
            mem_last_q[wr_idx] <= push_last;
        end
        if (drop && push_last) mem_last_q[wr_idx_prev] <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (load)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else if (load) begin
            out_data_q <= mem_q[rd_idx];
            out_last_q <= mem_last_q[rd_idx];
            out_vld_q  <= 1'b1;
        end else if (pop) begin
            out_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     ovf_q <= 1'b0;
        else if (ovf_clr) ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
    end

    assign demod_inphase    = out_data_q[SW-1:SAMPLE_BITS];
    assign demod_quadrature = out_data_q[SAMPLE_BITS-1:0];
    assign demod_valid      = out_vld_q;
    assign demod_last       = out_last_q;
    assign overflow         = ovf_q;
    assign is_armed         = (state_q == ST_ARMED) || (state_q == ST_QUALIFY);
    assign burst_active     = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_rx_burst.sv
// Bench for rx_burst: random I/Q streams, a window-scan reference model feeding
// an expected-output queue, and a monitor that checks every handshake.
module tb_rx_burst;

    localparam int SB = 8;
    localparam int BS = 625;
    localparam int QC = 4;
    localparam int FD = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          arm_burst = 1'b0;
    logic          is_armed;
    logic [SB:0]   energy_threshold = '0;
    logic [SB-1:0] rfchain_inphase = '0;
    logic [SB-1:0] rfchain_quadrature = '0;
    logic          rfchain_valid = 1'b0;
    logic [SB-1:0] demod_inphase;
    logic [SB-1:0] demod_quadrature;
    logic          demod_valid;
    logic          demod_ready = 1'b0;
    logic          demod_last;
    logic          burst_active;
    logic          overflow;

    rx_burst #(
        .SAMPLE_BITS  (SB),
        .BURST_SAMPLES(BS),
        .QUALIFY_COUNT(QC),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .arm_burst         (arm_burst),
        .is_armed          (is_armed),
        .energy_threshold  (energy_threshold),
        .rfchain_inphase   (rfchain_inphase),
        .rfchain_quadrature(rfchain_quadrature),
        .rfchain_valid     (rfchain_valid),
        .demod_inphase     (demod_inphase),
        .demod_quadrature  (demod_quadrature),
        .demod_valid       (demod_valid),
        .demod_ready       (demod_ready),
        .demod_last        (demod_last),
        .burst_active      (burst_active),
        .overflow          (overflow)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic [SB-1:0] i;
        logic [SB-1:0] q;
        logic          last;
    } exp_t;

    exp_t  exp_q[$];
    int    stim_i[$];
    int    stim_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pops = 0;
    int    ready_mode = 0;
    bit    mon_hold = 1'b0;
    logic [2*SB:0] hold_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int wrap8(input int x);
        int v;
        v = ((x % 256) + 256) % 256;
        return (v > 127) ? v - 256 : v;
    endfunction

    // Burst starts at the first window of QC consecutive samples with
    // |I|+|Q| >= thr; with a stalled sink only FD samples can ever be stored.
    task automatic model(input int thr, input bit stall);
        int   start;
        int   keep;
        bit   all_above;
        exp_t e;
        start = -1;
        for (int n = 0; n + QC <= stim_i.size() && start < 0; n++) begin
            all_above = 1'b1;
            for (int k = 0; k < QC; k++)
                if (iabs(stim_i[n+k]) + iabs(stim_q[n+k]) < thr) all_above = 1'b0;
            if (all_above) start = n;
        end
        if (start >= 0) begin
            keep = stall ? FD : BS;
            for (int k = 0; k < keep; k++) begin
                e.i    = 8'(stim_i[start+k]);
                e.q    = 8'(stim_q[start+k]);
                e.last = (k == keep - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cyc(input logic v, input int i, input int q);
        @(posedge clock);
        #1;
        rfchain_valid      = v;
        rfchain_inphase    = 8'(i);
        rfchain_quadrature = 8'(q);
    endtask

    task automatic feed(input int lo, input int hi, input int every);
        for (int n = lo; n <= hi; n++) begin
            for (int w = 1; w < every; w++) cyc(1'b0, int'($urandom), int'($urandom));
            cyc(1'b1, stim_i[n], stim_q[n]);
        end
        cyc(1'b0, int'($urandom), int'($urandom));
    endtask

    task automatic arm();
        @(posedge clock);
        #1;
        arm_burst = 1'b1;
        @(posedge clock);
        #1;
        arm_burst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((is_armed || burst_active) && n < 6000);
        checks++;
        if (is_armed || burst_active) begin
            errors++;
            $display("FAIL %s: got is_armed=%0b burst_active=%0b expected idle within 6000 cycles",
                     name, is_armed, burst_active);
        end
    endtask

    task automatic burst_stim(input int i0, input int q0);
        stim_i.delete();
        stim_q.delete();
        for (int k = 0; k < QC; k++) begin
            stim_i.push_back(i0);
            stim_q.push_back(q0);
        end
        for (int k = 0; k < 700; k++) begin
            stim_i.push_back(wrap8(int'($urandom)));
            stim_q.push_back(wrap8(int'($urandom)));
        end
    endtask

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clock);
            #1;
            c++;
            case (ready_mode)
                0:       demod_ready = 1'b1;
                1:       demod_ready = 1'b0;
                default: demod_ready = (c % 3 == 0);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) begin
                    checks++;
                    if (!(demod_valid && {demod_inphase, demod_quadrature, demod_last} == hold_val)) begin
                        errors++;
                        $display("FAIL hold_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                                 demod_valid, {demod_inphase, demod_quadrature, demod_last}, hold_val);
                    end
                end
                mon_hold = demod_valid && !demod_ready;
                hold_val = {demod_inphase, demod_quadrature, demod_last};
                if (demod_valid && demod_ready) begin
                    checks++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got I=%0d Q=%0d last=%0b expected no output",
                                 $signed(demod_inphase), $signed(demod_quadrature), demod_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({demod_inphase, demod_quadrature, demod_last} !== e) begin
                            errors++;
                            $display("FAIL output_sample: got I=%0d Q=%0d last=%0b expected I=%0d Q=%0d last=%0b",
                                     $signed(demod_inphase), $signed(demod_quadrature), demod_last,
                                     $signed(e.i), $signed(e.q), e.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int mag;
        int sgn;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hold_outputs", {demod_valid, demod_last, is_armed, burst_active, overflow}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_flags", {demod_valid, demod_last, is_armed, burst_active, overflow}, 0);
        chk("reset_data", {demod_inphase, demod_quadrature}, 0);

        // Noise, a broken run, then a qualifying counter ramp.
        energy_threshold = 40;
        stim_i.delete();
        stim_q.delete();
        for (int n = 0; n < 2000; n++) begin
            mag = int'($urandom_range(0, 10));
            sgn = ($urandom_range(0, 1) == 1) ? -1 : 1;
            stim_i.push_back(sgn * mag);
            stim_q.push_back((($urandom_range(0, 1) == 1) ? -1 : 1) * (10 - mag));
        end
        for (int n = 0; n < 3; n++) begin
            stim_i.push_back(50);
            stim_q.push_back(0);
        end
        stim_i.push_back(5);
        stim_q.push_back(0);
        for (int k = 0; k < 704; k++) begin
            stim_i.push_back(wrap8(50 + k));
            stim_q.push_back(0);
        end
        model(40, 1'b0);
        arm();
        feed(0, 1999, 1);
        @(negedge clock);
        chk("noise_is_armed", is_armed, 1);
        chk("noise_no_burst", burst_active, 0);
        feed(2000, 2003, 1);
        repeat (2) @(negedge clock);
        chk("broken_run_armed", is_armed, 1);
        chk("broken_run_no_burst", burst_active, 0);
        feed(2004, stim_i.size() - 1, 1);
        wait_idle("ramp_burst_idle");
        chk("ramp_all_received", exp_q.size(), 0);
        chk("ramp_no_overflow", overflow, 0);

        // Largest magnitude exactly at threshold.
        energy_threshold = 256;
        burst_stim(-128, -128);
        model(256, 1'b0);
        arm();
        feed(0, stim_i.size() - 1, 1);
        wait_idle("max_mag_idle");
        chk("max_mag_all_received", exp_q.size(), 0);

        // One above the largest magnitude never qualifies.
        energy_threshold = 257;
        stim_i.delete();
        stim_q.delete();
        for (int n = 0; n < 100; n++) begin
            stim_i.push_back(-128);
            stim_q.push_back(-128);
        end
        model(257, 1'b0);
        arm();
        feed(0, 99, 1);
        repeat (3) @(negedge clock);
        chk("thr257_armed", is_armed, 1);
        chk("thr257_no_burst", burst_active, 0);
        chk("thr257_no_output", exp_q.size(), 0);

        // Reset in the middle of a capture (still armed from above).
        energy_threshold = 40;
        burst_stim(60, -20);
        model(40, 1'b0);
        pops = 0;
        feed(0, 304, 1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {demod_valid, demod_last, is_armed, burst_active, overflow, demod_inphase, demod_quadrature}, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        chk("after_reset_idle", {is_armed, burst_active, demod_valid}, 0);
        chk("pops_before_reset", (pops >= 290 && pops <= 305), 1);
        exp_q.delete();

        // Clean burst after reset.
        burst_stim(-45, 7);
        model(40, 1'b0);
        arm();
        feed(0, stim_i.size() - 1, 1);
        wait_idle("post_reset_idle");
        chk("post_reset_all_received", exp_q.size(), 0);

        // Sink stalled for the whole capture.
        ready_mode = 1;
        burst_stim(30, 30);
        model(40, 1'b1);
        arm();
        feed(0, stim_i.size() - 1, 1);
        @(negedge clock);
        chk("stall_drain_active", burst_active, 1);
        chk("stall_overflow", overflow, 1);
        chk("stall_valid_held", demod_valid, 1);
        ready_mode = 0;
        wait_idle("stall_idle");
        chk("stall_all_received", exp_q.size(), 0);
        chk("overflow_sticky", overflow, 1);

        // Re-arm clears overflow; sparse input with a 1-of-3 sink.
        arm();
        @(negedge clock);
        chk("arm_clears_overflow", overflow, 0);
        ready_mode = 2;
        burst_stim(0, -90);
        model(40, 1'b0);
        feed(0, stim_i.size() - 1, 4);
        wait_idle("toggle_idle");
        chk("toggle_all_received", exp_q.size(), 0);
        chk("toggle_no_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_burst.md
Name: rx_burst

Overview:
- Receive-side counterpart of the GMSK transmit burst controller.
- Sits between the RF chain's I/Q sample output and the GMSK demodulator.
- Once armed, it watches incoming I/Q samples for burst energy and qualifies a burst start. It then captures a fixed-length burst and hands it to the demodulator through a FIFO with a valid/ready handshake.

Parameters:
- SAMPLE_BITS, 8, signed I and Q width (matches the modulator/RF-chain sample width).
- BURST_SAMPLES, 625, samples per burst (156.25 symbols x 4 samples/symbol).
- QUALIFY_COUNT, 4, consecutive above-threshold samples required to declare a burst.
- FIFO_DEPTH, 16, capture FIFO entries (power of two).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm_burst  in  1  one-cycle request to arm the receiver; honoured only in IDLE.
- is_armed  out  1  high in ARMED and QUALIFY.
- energy_threshold  in  SAMPLE_BITS+1  unsigned magnitude threshold; sampled every cycle.
- rfchain_inphase  in  SAMPLE_BITS  signed I sample.
- rfchain_quadrature  in  SAMPLE_BITS  signed Q sample.
- rfchain_valid  in  1  I/Q sample present this cycle.
- demod_inphase  out  SAMPLE_BITS  captured I sample.
- demod_quadrature  out  SAMPLE_BITS  captured Q sample.
- demod_valid  out  1  output sample valid.
- demod_ready  in  1  demodulator accepts the output sample.
- demod_last  out  1  marks the final sample of a burst; qualified by demod_valid.
- burst_active  out  1  high in CAPTURE and DRAIN.
- overflow  out  1  sticky flag: a captured sample was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all outputs 0; FIFO emptied; counters 0.
  - Assertion mid-burst aborts the burst immediately and discards FIFO contents.
- Magnitude computation:
  - mag = |I|+|Q|, computed at SAMPLE_BITS+1 bits unsigned. Sign-extend before abs, so |-128|=128; maximum is 256.
  - mag is registered, giving one cycle of latency.
  - Above-threshold means mag >= energy_threshold.
- Input handling:
  - A sample is accepted on every cycle with rfchain_valid=1; there is no backpressure toward the RF chain.
  - Cycles with rfchain_valid=0 change no counter and no delay-line contents.
- State machine:
  - IDLE: arm_burst=1 -> ARMED. Entering ARMED clears overflow.
  - ARMED: an accepted above-threshold sample -> QUALIFY with run=1.
  - QUALIFY: each accepted above-threshold sample increments run; an accepted below-threshold sample returns to ARMED with run=0. When run reaches QUALIFY_COUNT -> CAPTURE. With QUALIFY_COUNT=1, the first above-threshold sample goes directly from ARMED to CAPTURE.
  - CAPTURE: pushes BURST_SAMPLES samples in strict arrival order. The first pushed sample is the first sample of the qualifying run, held in a QUALIFY_COUNT-deep delay line that advances on accepted samples. Threshold is ignored in CAPTURE. After the BURST_SAMPLES-th push -> DRAIN.
  - DRAIN: no further pushes. Once the last sample has been handshaken out (demod_valid & demod_ready & demod_last) -> IDLE.
  - arm_burst outside IDLE is ignored.
- Burst length:
  - Capture consumes BURST_SAMPLES+QUALIFY_COUNT-1 accepted input samples in total, counting from the run start, with BURST_SAMPLES pushes.
  - Samples arriving after the final push are discarded.
- FIFO full:
  - A push while the FIFO is full drops that sample and sets overflow.
  - The push counter still advances, so burst length is preserved.
  - If the dropped sample is the final one, demod_last is attached to the last sample actually stored.
- Simultaneous push and pop on a full FIFO: both occur; no drop.
- Output handshake:
  - demod_* outputs are registered.
  - Data and last hold stable while demod_valid=1 and demod_ready=0.
  - Transfer happens on demod_valid & demod_ready.
  - Minimum latency from a pushed sample to demod_valid on an empty FIFO is 2 cycles.
- demod_last: high on exactly one transferred sample per burst.

Test Plan:
- Noise of mag 10 with threshold 40, armed, for 2000 samples -> stays ARMED, is_armed=1, demod_valid never asserts.
- Armed, 3 samples of I=50,Q=0 followed by one of I=5 -> returns to ARMED. Then 4 samples of I=50 -> CAPTURE. Feed 700 samples with a counter in I -> 625 transfers; the first has I=50; I increments thereafter; demod_last only on the 625th; then IDLE with is_armed=0.
- I=-128,Q=-128 with threshold 256 -> qualifies. Same input with threshold 257 -> never qualifies.
- demod_ready=0 throughout capture -> exactly 16 samples stored, overflow=1, demod_last on the 16th stored sample. The next arm clears overflow.
- demod_ready toggling 1-of-3 with rfchain_valid every 4th clock -> no drops, overflow=0, output order preserved, data stable while stalled.
- reset_n pulsed low for 1 cycle at push 300 -> all outputs 0 asynchronously, state IDLE. A re-arm then captures a full, clean 625-sample burst.
